// File: rtl/br_fifo_multi_channel_flops.sv
// br_fifo_multi_channel_flops
//
// Several independent logical FIFOs sharing one push port. Every pushed entry
// is steered to the channel named by push_ch; each channel drains through its
// own pop port. Storage is a flop array with Depth entries per channel. Each
// channel has its own read/write pointers and occupancy counter, so a stalled
// consumer on one channel never blocks traffic on another.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. The producer holds push_valid, push_ch
// and push_data stable while push_ready is low. This block holds pop_valid[c]
// and pop_data[c] stable while pop_ready[c] is low. push_ready never depends
// on push_valid or on any pop_ready.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   push_valid/ready/ch/data  shared push port
//   pop_valid/ready/data      per-channel pop ports; channel c at [c*Width +: Width]
//   full, full_next           per-channel full flag and its next-cycle value
//   empty, empty_next         per-channel empty flag and its next-cycle value
//   items, items_next         per-channel occupancy and its next-cycle value
//   slots, slots_next         per-channel free entries and its next-cycle value
//   total_items               registered sum of all channel occupancies
module br_fifo_multi_channel_flops #(
    parameter int NumChannels  = 2,
    parameter int Depth        = 2,
    parameter int Width        = 1,
    parameter int EnableBypass = 1,
    localparam int ChWidth     = ($clog2(NumChannels) > 1) ? $clog2(NumChannels) : 1,
    localparam int CountWidth  = $clog2(Depth + 1),
    localparam int TotalWidth  = $clog2(NumChannels * Depth + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push_valid,
    output logic                              push_ready,
    input  logic [ChWidth-1:0]                push_ch,
    input  logic [Width-1:0]                  push_data,
    output logic [NumChannels-1:0]            pop_valid,
    input  logic [NumChannels-1:0]            pop_ready,
    output logic [NumChannels*Width-1:0]      pop_data,
    output logic [NumChannels-1:0]            full,
    output logic [NumChannels-1:0]            full_next,
    output logic [NumChannels*CountWidth-1:0] slots,
    output logic [NumChannels*CountWidth-1:0] slots_next,
    output logic [NumChannels-1:0]            empty,
    output logic [NumChannels-1:0]            empty_next,
    output logic [NumChannels*CountWidth-1:0] items,
    output logic [NumChannels*CountWidth-1:0] items_next,
    output logic [TotalWidth-1:0]             total_items
);

    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    logic [CountWidth-1:0] items_q [NumChannels];
    logic [CountWidth-1:0] items_d [NumChannels];
    logic [PtrWidth-1:0]   wr_ptr  [NumChannels];
    logic [PtrWidth-1:0]   rd_ptr  [NumChannels];
    logic [Width-1:0]      mem     [NumChannels][Depth];
    logic [TotalWidth-1:0] total_q;
    logic [TotalWidth-1:0] total_d;

    logic [NumChannels-1:0] full_int;
    logic [NumChannels-1:0] empty_int;
    logic [NumChannels-1:0] push_hit;
    logic [NumChannels-1:0] push_to;
    logic [NumChannels-1:0] bypass;
    logic [NumChannels-1:0] pop_valid_int;
    logic [NumChannels-1:0] pop_int;
    logic [NumChannels-1:0] write_en;
    logic                   push;

    // Pointers count 0..Depth-1 and wrap, so Depth need not be a power of 2.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    always_comb begin
        full_int  = '0;
        empty_int = '0;
        for (int c = 0; c < NumChannels; c++) begin
            full_int[c]  = (items_q[c] == CountWidth'(Depth));
            empty_int[c] = (items_q[c] == '0);
        end
    end

    // Ready looks only at the registered full flag: a pop in the same cycle
    // does not open a slot for the push.
    assign push_ready = !full_int[push_ch];
    assign push       = push_valid && push_ready;

    always_comb begin
        push_hit      = '0;
        push_to       = '0;
        bypass        = '0;
        pop_valid_int = '0;
        pop_int       = '0;
        write_en      = '0;
        total_d       = '0;
        for (int c = 0; c < NumChannels; c++) begin
            items_d[c]       = '0;
            push_hit[c]      = push_valid && (int'(push_ch) == c);
            push_to[c]       = push && push_hit[c];
            // An empty channel can present the incoming push directly; gated
            // by !rst so pop_valid reads 0 throughout reset.
            bypass[c]        = (EnableBypass != 0) && !rst && empty_int[c] && push_hit[c];
            pop_valid_int[c] = !empty_int[c] || bypass[c];
            pop_int[c]       = pop_valid_int[c] && pop_ready[c];
            // A bypassed entry that is consumed immediately never lands in
            // storage; both pointers still step so they stay equal.
            write_en[c]      = push_to[c] && !(bypass[c] && pop_ready[c]);
            items_d[c]       = items_q[c] + CountWidth'(push_to[c]) - CountWidth'(pop_int[c]);
            total_d          = total_d + TotalWidth'(items_d[c]);
        end
    end

    assign pop_valid   = pop_valid_int;
    assign full        = full_int;
    assign empty       = empty_int;
    assign total_items = total_q;

    always_comb begin
        items      = '0;
        items_next = '0;
        slots      = '0;
        slots_next = '0;
        full_next  = '0;
        empty_next = '0;
        pop_data   = '0;
        for (int c = 0; c < NumChannels; c++) begin
            items[c*CountWidth +: CountWidth]      = items_q[c];
            slots[c*CountWidth +: CountWidth]      = CountWidth'(Depth) - items_q[c];
            items_next[c*CountWidth +: CountWidth] = items_d[c];
            slots_next[c*CountWidth +: CountWidth] = CountWidth'(Depth) - items_d[c];
            full_next[c]                           = (items_d[c] == CountWidth'(Depth));
            empty_next[c]                          = (items_d[c] == '0);
            pop_data[c*Width +: Width]             = bypass[c] ? push_data : mem[c][rd_ptr[c]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NumChannels; c++) begin
                items_q[c] <= '0;
                wr_ptr[c]  <= '0;
                rd_ptr[c]  <= '0;
            end
            total_q <= '0;
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                items_q[c] <= items_d[c];
                if (push_to[c]) begin
                    wr_ptr[c] <= ptr_inc(wr_ptr[c]);
                end
                if (pop_int[c]) begin
                    rd_ptr[c] <= ptr_inc(rd_ptr[c]);
                end
            end
            total_q <= total_d;
        end
    end

    // Payload storage carries no reset; contents are only observed when valid.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NumChannels; c++) begin
            if (write_en[c]) begin
                mem[c][wr_ptr[c]] <= push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_valid) begin
            assert (int'(push_ch) < NumChannels);
        end
    end

endmodule
